alu_seq_divider: RTL and testbench
==================================

// Module: alu_seq_divider
// PURPOSE
//   Multi-cycle signed restoring divider. It is the inverse operation of the ALU multiply path.
//   It returns a 64-bit result in the same HI/LO format as the ALU multiply result, so HI/LO
//   (Z) register writeback needs no change: C[63:32] = remainder (HI), C[31:0] = quotient (LO).
//   It sits beside the ALU, is started by the control unit, and is polled via busy/done.
// PARAMETERS
//   WIDTH  32  operand width; result width is 2*WIDTH
// PORTS
//   clock         in   1        single clock, rising edge
//   clear         in   1        asynchronous, active-high reset
//   start         in   1        request; sampled only when busy=0
//   A             in   WIDTH    dividend, two's complement
//   B             in   WIDTH    divisor, two's complement
//   busy          out  1        high from the accepting edge until done
//   done          out  1        one-cycle pulse; C valid from this cycle
//   div_by_zero   out  1        high with done when B was 0; held until next accept
//   C             out  2*WIDTH  {remainder, quotient}; held until next accept
// BEHAVIOUR
//   - Reset (clear=1, async): state=IDLE, busy=0, done=0, div_by_zero=0, C=0, internal regs=0.
//     Clear mid-operation aborts the operation; no done is produced.
//   - States: IDLE -> RUN (WIDTH cycles) -> FIX (1) -> DONE (1) -> IDLE.
//   - IDLE: on an edge with start=1, latch A, B, sign_q = A[msb]^B[msb], sign_r = A[msb],
//     |A|, |B|; clear div_by_zero; busy=1.
//     * If B != 0: go to RUN with iteration counter = 0 and partial remainder R = 0.
//     * If B == 0: go directly to DONE.
//   - RUN, each cycle (unsigned restoring step on WIDTH+1-bit R):
//     * R = {R, next dividend bit, MSB first}.
//     * If R >= |B|: R -= |B| and shift quotient bit 1; else shift quotient bit 0.
//     * Counter increments; after iteration WIDTH-1, go to FIX.
//   - FIX: quotient negated if sign_q; remainder negated if sign_r. Truncation toward zero;
//     remainder sign follows the dividend. Result is written to C.
//   - DONE: done=1 for exactly one cycle, busy=0 in the same cycle, then IDLE.
//     * Normal latency: done is high WIDTH+2 cycles after the accepting edge (34 for WIDTH=32).
//     * Divide-by-zero: done is high 1 cycle after accept, div_by_zero=1,
//       C = {A, all-ones}, i.e. remainder = dividend, quotient = -1.
//   - start while busy=1 is ignored; it is not queued.
//     start in the DONE cycle is also ignored; it is accepted from the IDLE cycle onward.
//   - Operand changes on A/B after accept have no effect; operands are latched.
//   - Overflow (-2^(WIDTH-1) / -1): quotient = 0x80000000, remainder = 0, no flag.
//     The result wraps modulo 2^WIDTH.
//   - C, div_by_zero and done change only at state transitions; C is never partially updated.
// TESTING
//   1. A=100, B=7, start 1 cycle -> done exactly 34 cycles later, C = {32'd2, 32'd14},
//      div_by_zero=0.
//   2. A=-7 (0xFFFFFFF9), B=2 -> C = {32'hFFFFFFFF, 32'hFFFFFFFD} (r=-1, q=-3).
//      A=7, B=-2 -> C = {32'd1, 32'hFFFFFFFD}.
//   3. A=5, B=0 -> done 1 cycle after accept, div_by_zero=1, C = {32'd5, 32'hFFFFFFFF}.
//      A following valid op clears div_by_zero.
//   4. A=0x80000000, B=0xFFFFFFFF -> C = {32'd0, 32'h80000000}.
//      A=0x80000000, B=1 -> C = {32'd0, 32'h80000000}.
//   5. start=1 held high throughout an operation with changing A/B -> exactly one done per
//      accepted start, with the result of the latched operands. Back-to-back ops complete
//      with no lost or duplicate done.
//   6. Assert clear at cycle 10 of a run -> all outputs 0 immediately (async), no done pulse.
//      A new start after release returns a correct result.

Source files
------------

// File: rtl/alu_seq_divider.sv
// rtl/alu_seq_divider.sv - multi-cycle signed restoring divider, {remainder, quotient} result
module alu_seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 clear,
  input  logic                 start,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 busy,
  output logic                 done,
  output logic                 div_by_zero,
  output logic [2*WIDTH-1:0]   C
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t            state;
  logic [WIDTH:0]    rem;
  logic [WIDTH-1:0]  dvd;
  logic [WIDTH-1:0]  abs_b;
  logic [CW-1:0]     cnt;
  logic              sign_q;
  logic              sign_r;

  logic [WIDTH:0]    rem_shift;
  logic [WIDTH:0]    rem_diff;
  logic              fits;
  logic [WIDTH-1:0]  abs_a_in;
  logic [WIDTH-1:0]  abs_b_in;
  logic [WIDTH-1:0]  q_fix;
  logic [WIDTH-1:0]  r_fix;

  // dvd holds the remaining dividend bits and collects quotient bits from the bottom
  always_comb begin
    rem_shift = {rem[WIDTH-1:0], dvd[WIDTH-1]};
    rem_diff  = rem_shift - {1'b0, abs_b};
    fits      = (rem_shift >= {1'b0, abs_b});
    abs_a_in  = A[WIDTH-1] ? -A : A;
    abs_b_in  = B[WIDTH-1] ? -B : B;
    q_fix     = sign_q ? -dvd : dvd;
    r_fix     = sign_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      C           <= '0;
      rem         <= '0;
      dvd         <= '0;
      abs_b       <= '0;
      cnt         <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sign_q      <= A[WIDTH-1] ^ B[WIDTH-1];
            sign_r      <= A[WIDTH-1];
            dvd         <= abs_a_in;
            abs_b       <= abs_b_in;
            rem         <= '0;
            cnt         <= '0;
            div_by_zero <= (B == '0);
            if (B == '0) begin
              C     <= {A, {WIDTH{1'b1}}};
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              busy  <= 1'b1;
              state <= RUN;
            end
          end
        end
        RUN: begin
          rem <= fits ? rem_diff : rem_shift;
          dvd <= {dvd[WIDTH-2:0], fits};
          cnt <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          C     <= {r_fix, q_fix};
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_divider.sv
// tb/tb_alu_seq_divider.sv - directed self-checking bench for alu_seq_divider
module tb_alu_seq_divider;

  logic        clock;
  logic        clear;
  logic        start;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [63:0] C;

  int n_checks = 0;
  int n_pass   = 0;

  alu_seq_divider #(.WIDTH(32)) dut (
    .clock       (clock),
    .clear       (clear),
    .start       (start),
    .A           (A),
    .B           (B),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .C           (C)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp_c, input logic exp_dz, input int exp_lat);
    int cyc;
    @(negedge clock);
    A = a;
    B = b;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    A = ~a;
    B = ~b;
    cyc = 1;
    if (exp_lat > 1) check({tag, "_busy"}, 64'(busy), 64'd1);
    while (!done && cyc < 200) begin
      @(posedge clock);
      #1;
      cyc++;
    end
    check({tag, "_lat"}, 64'(cyc), 64'(exp_lat));
    check({tag, "_c"}, C, exp_c);
    check({tag, "_dz"}, 64'(div_by_zero), 64'(exp_dz));
    check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    @(posedge clock);
    #1;
    check({tag, "_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    int ndone;
    clear = 1'b1;
    start = 1'b0;
    A = '0;
    B = '0;
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_dz", 64'(div_by_zero), 64'd0);
    check("rst_c", C, 64'd0);
    @(negedge clock);
    @(negedge clock);
    clear = 1'b0;

    run_op("pos",     32'd100,        32'd7,          {32'd2, 32'd14},                  1'b0, 34);
    run_op("neg_a",   32'hFFFFFFF9,   32'd2,          {32'hFFFFFFFF, 32'hFFFFFFFD},     1'b0, 34);
    run_op("neg_b",   32'd7,          32'hFFFFFFFE,   {32'd1, 32'hFFFFFFFD},            1'b0, 34);
    run_op("neg_ab",  32'hFFFFFF9C,   32'hFFFFFFF9,   {32'hFFFFFFFE, 32'd14},           1'b0, 34);
    run_op("small",   32'd3,          32'd7,          {32'd3, 32'd0},                   1'b0, 34);
    run_op("dz",      32'd5,          32'd0,          {32'd5, 32'hFFFFFFFF},            1'b1, 1);
    run_op("after_dz",32'd100,        32'd7,          {32'd2, 32'd14},                  1'b0, 34);
    run_op("ovf",     32'h80000000,   32'hFFFFFFFF,   {32'd0, 32'h80000000},            1'b0, 34);
    run_op("min_1",   32'h80000000,   32'd1,          {32'd0, 32'h80000000},            1'b0, 34);

    // start held high with operands churning while busy
    @(negedge clock);
    A = 32'd20;
    B = 32'd3;
    start = 1'b1;
    ndone = 0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clock);
      if (done) begin
        ndone++;
        if (ndone == 1) begin
          check("hold_c1", C, {32'd2, 32'd6});
          check("hold_lat1", 64'(k), 64'd34);
          A = 32'hFFFFFFF7;
          B = 32'd4;
        end else if (ndone == 2) begin
          check("hold_c2", C, {32'hFFFFFFFF, 32'hFFFFFFFE});
          check("hold_lat2", 64'(k), 64'd69);
          A = 32'd1;
          B = 32'd1;
        end
      end else if (busy) begin
        A = $urandom;
        B = $urandom;
      end
    end
    check("hold_ndone", 64'(ndone), 64'd2);
    start = 1'b0;
    @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;

    // async clear in the middle of a run
    @(negedge clock);
    A = 32'd100;
    B = 32'd7;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clock);
    #2;
    clear = 1'b1;
    #1;
    check("clr_busy", 64'(busy), 64'd0);
    check("clr_done", 64'(done), 64'd0);
    check("clr_dz", 64'(div_by_zero), 64'd0);
    check("clr_c", C, 64'd0);
    @(negedge clock);
    @(negedge clock);
    clear = 1'b0;
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (done) ndone++;
    end
    check("clr_no_done", 64'(ndone), 64'd0);
    run_op("post_clr", 32'hFFFFFF9C, 32'hFFFFFFF9, {32'hFFFFFFFE, 32'd14}, 1'b0, 34);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
